// File: rtl/alu_op_driver.sv
// rtl/alu_op_driver.sv - command FIFO and phase-locked operand driver for the 3-phase 4-bit ALU
// Optional golden-model scoreboard (rsp_mismatch, err_count): define ALU_DRV_SCOREBOARD_EN.
module alu_op_driver #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  output logic [3:0]       rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             rsp_mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_EXEC = 2'd1,
    PH_WB   = 2'd2
  } phase_t;

  phase_t        phase, phase_nxt;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop, boundary, capture, fire;
  logic          slot_valid, cap_valid;
  logic [9:0]    head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PH_IDLE;
    else        phase <= phase_nxt;
  end

  // Mirrors the ALU's free-running IDLE -> EXEC -> WB sequence
  always_comb begin
    phase_nxt = PH_IDLE;
    case (phase)
      PH_IDLE: phase_nxt = PH_EXEC;
      PH_EXEC: phase_nxt = PH_WB;
      default: phase_nxt = PH_IDLE;
    endcase
  end

  assign boundary  = (phase == PH_WB);
  assign capture   = (phase == PH_IDLE);
  assign full      = (count == CW'(DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = boundary && (count != '0);
  assign fire      = capture && cap_valid;
  assign head      = mem[rd_ptr];
  assign busy      = (count != '0) || slot_valid || cap_valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Operands change only at the window boundary so they stay stable for all three ALU phases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      slot_valid <= 1'b0;
      cap_valid  <= 1'b0;
    end else begin
      if (pop) begin
        alu_a  <= head[9:6];
        alu_b  <= head[5:2];
        alu_op <= head[1:0];
      end
      if (boundary) begin
        slot_valid <= pop;
        cap_valid  <= slot_valid;
      end else if (capture) begin
        cap_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      rsp_valid <= fire;
      if (fire) begin
        rsp_result <= alu_result;
        rsp_flags  <= {alu_carry, alu_zero, alu_overflow};
      end
    end
  end

`ifdef ALU_DRV_SCOREBOARD_EN
  // Expected {result, carry, zero, overflow}; carry on sub is the borrow out
  function automatic logic [6:0] golden(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    logic [4:0] r;
    logic       c, v;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin
        r = {1'b0, a} + {1'b0, b};
        c = r[4];
        v = (a[3] == b[3]) && (a[3] != r[3]);
      end
      2'b01: begin
        r = {1'b0, a} - {1'b0, b};
        c = r[4];
        v = (a[3] != b[3]) && (a[3] != r[3]);
      end
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return {r[3:0], c, (r[3:0] == 4'h0), v};
  endfunction

  logic [6:0] slot_exp, cap_exp;
  logic       mismatch_now;

  assign mismatch_now = ({alu_result, alu_carry, alu_zero, alu_overflow} != cap_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_exp     <= '0;
      cap_exp      <= '0;
      rsp_mismatch <= 1'b0;
      err_count    <= '0;
    end else begin
      if (pop)      slot_exp <= golden(head[9:6], head[5:2], head[1:0]);
      if (boundary) cap_exp  <= slot_exp;
      if (fire) begin
        rsp_mismatch <= mismatch_now;
        if (mismatch_now && (err_count != '1)) err_count <= err_count + ERR_W'(1);
      end
    end
  end
`else
  assign rsp_mismatch = 1'b0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// tb/tb_alu_op_driver.sv - self-checking bench for alu_op_driver with a 3-phase ALU model
// Expected responses come from a queue-level model of the command stream.
module tb_alu_op_driver;
  localparam int DEPTH   = 4;
  localparam int ERR_W   = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef ALU_DRV_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [3:0]       cmd_a = '0, cmd_b = '0;
  logic [1:0]       cmd_op = '0;
  logic             cmd_ready;
  logic [3:0]       alu_a, alu_b;
  logic [1:0]       alu_op;
  logic [3:0]       alu_result;
  logic             alu_carry, alu_zero, alu_overflow;
  logic             rsp_valid, rsp_mismatch, busy;
  logic [3:0]       rsp_result;
  logic [2:0]       rsp_flags;
  logic [ERR_W-1:0] err_count;
  logic             force_en = 1'b0;

  int checks = 0, failures = 0;
  int pcount = 0, rel_mark = 0, rsp_seen = 0, lat = 0;
  bit saw_full = 1'b0;

  alu_op_driver #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_mismatch(rsp_mismatch), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcount <= pcount + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Integer/signed-range reference: {result, carry(borrow), zero, overflow}
  function automatic logic [6:0] ref_op(input int a, input int b, input int op);
    int r, s, sa, sb;
    logic c, v;
    logic [3:0] res;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 15); s = sa + sb; v = (s > 7) || (s < -8); end
      1: begin r = a - b; c = (a < b);  s = sa - sb; v = (s > 7) || (s < -8); end
      2: r = a & b;
      default: r = a | b;
    endcase
    res = r[3:0];
    return {res, c, (res == 4'h0), v};
  endfunction

  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    logic [6:0] r;
    r = ref_op(a, b, op);
    if (force_en && op == 2'd0 && a == 4'd2 && b == 4'd2) r[6:3] = 4'h3;
    return r;
  endfunction

  // ALU: registers its outputs at the end of WB from operands held over the window
  int alu_ph;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ph <= 0;
      {alu_result, alu_carry, alu_zero, alu_overflow} <= '0;
    end else begin
      alu_ph <= (alu_ph == 2) ? 0 : alu_ph + 1;
      if (alu_ph == 2) {alu_result, alu_carry, alu_zero, alu_overflow} <= alu_fn(alu_a, alu_b, alu_op);
    end
  end

  typedef struct { logic [3:0] a; logic [3:0] b; logic [1:0] op; } cmd_t;
  typedef struct { int due; logic [6:0] act; logic mis; } pend_t;
  cmd_t       q[$];
  pend_t      pend[$];
  int         cyc = 0, m_err = 0;
  logic [3:0] m_a = '0, m_b = '0;
  logic [1:0] m_op = '0;

  // Model: pop every third cycle if anything is queued; response 5 cycles after the pop
  initial begin
    cmd_t  e;
    pend_t p;
    bit    do_pop, do_push;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete(); pend.delete();
        cyc = 0; m_err = 0; m_a = '0; m_b = '0; m_op = '0;
      end else begin
        while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
        do_pop  = (cyc % 3 == 2) && (q.size() > 0);
        do_push = cmd_valid && (q.size() < DEPTH);
        if (do_pop) begin
          e = q.pop_front();
          m_a = e.a; m_b = e.b; m_op = e.op;
          p.due = cyc + 5;
          p.act = alu_fn(e.a, e.b, e.op);
          p.mis = SB && (p.act != ref_op(e.a, e.b, e.op));
          pend.push_back(p);
        end
        if (do_push) begin
          e.a = cmd_a; e.b = cmd_b; e.op = cmd_op;
          q.push_back(e);
        end
        cyc++;
        if (pend.size() > 0 && pend[0].due == cyc && pend[0].mis && m_err < ERR_MAX) m_err++;
      end
    end
  end

  initial begin
    bit exp_v, exp_busy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        chk("rst_rsp", {rsp_valid, rsp_result, rsp_flags, rsp_mismatch}, 0);
        chk("rst_err", err_count, 0);
        chk("rst_busy", busy, 0);
      end else begin
        exp_v    = (pend.size() > 0) && (pend[0].due == cyc);
        exp_busy = (q.size() > 0) || ((pend.size() > 0) && (pend[pend.size()-1].due > cyc));
        chk("cmd_ready", cmd_ready, (q.size() < DEPTH) ? 1 : 0);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", alu_op, m_op);
        chk("rsp_valid", rsp_valid, exp_v);
        chk("err_count", err_count, m_err);
        chk("busy", busy, exp_busy);
        if (exp_v) begin
          chk("rsp_result", rsp_result, pend[0].act[6:3]);
          chk("rsp_flags", rsp_flags, pend[0].act[2:0]);
          chk("rsp_mismatch", rsp_mismatch, pend[0].mis);
        end
        if (rsp_valid) rsp_seen++;
        if (!cmd_ready) saw_full = 1'b1;
      end
    end
  end

  task automatic push_now(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk);
      ok = cmd_ready;
    end
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    @(negedge clk); #1;
    push_now(a, b, op);
  endtask

  task automatic idle();
    @(negedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int l);
    bit found;
    found = 1'b0;
    l = -1;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1'b1; l = pcount - rel_mark; end
    end
    if (!found) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    chk("pin_add_F_1", ref_op(15, 1, 0), 7'h06);
    chk("pin_add_7_1", ref_op(7, 1, 0), 7'h41);
    chk("pin_sub_3_5", ref_op(3, 5, 1), 7'h74);
    chk("pin_and_A_5", ref_op(10, 5, 2), 7'h02);
    chk("pin_sub_8_1", ref_op(8, 1, 1), 7'h39);

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    rel_mark = pcount;
    push_now(4'hF, 4'h1, 2'b00);
    idle();
    wait_rsp(lat);
    chk("t1_latency", lat, 7);
    chk("t1_result", rsp_result, 4'h0);
    chk("t1_flags", rsp_flags, 3'b110);
    chk("t1_mismatch", rsp_mismatch, 0);

    push(4'h7, 4'h1, 2'b00);
    push(4'h3, 4'h5, 2'b01);
    push(4'hA, 4'h5, 2'b10);
    idle();
    repeat (15) @(negedge clk);
    chk("t2_err", err_count, 0);

    push(4'h1, 4'h2, 2'b00);
    push(4'h9, 4'h9, 2'b00);
    push(4'h8, 4'h1, 2'b01);
    push(4'hC, 4'hA, 2'b11);
    push(4'h5, 4'h5, 2'b01);
    push(4'h6, 4'h3, 2'b10);
    idle();
    repeat (25) @(negedge clk);
    chk("t3_saw_full", saw_full, 1);

    force_en = 1'b1;
    push(4'h2, 4'h2, 2'b00);
    idle();
    wait_rsp(lat);
    chk("t4_forced_result", rsp_result, 4'h3);
    chk("t4_forced_mismatch", rsp_mismatch, SB);
    chk("t4_err_one", err_count, SB ? 1 : 0);
    repeat (4) push(4'h2, 4'h2, 2'b00);
    idle();
    repeat (25) @(negedge clk);
    chk("t4_err_sat", err_count, SB ? ERR_MAX : 0);
    force_en = 1'b0;

    lat = rsp_seen;
    repeat (9) @(negedge clk);
    chk("t5_no_rsp", rsp_seen, lat);
    chk("t5_busy", busy, 0);
    chk("t5_alu_hold", {alu_a, alu_b, alu_op}, {4'h2, 4'h2, 2'b00});

    push(4'h1, 4'h1, 2'b00);
    push(4'h2, 4'h3, 2'b00);
    push(4'h4, 4'h4, 2'b10);
    idle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((pcount - rel_mark) % 3 == 1) break;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_alu_a", alu_a, 0);
    #1 rst_n = 1'b1;
    rel_mark = pcount;
    push_now(4'h5, 4'h3, 2'b01);
    idle();
    wait_rsp(lat);
    chk("t6_latency", lat, 7);
    chk("t6_result", rsp_result, 4'h2);
    chk("t6_flags", rsp_flags, 3'b000);
    chk("t6_err", err_count, 0);
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
